prog_loader: RTL
================

Name: prog_loader

Overview:
Byte-stream program loader that writes instruction words into the 32-entry instruction memory that the processor fetches from. It is the writer side of that instruction-memory interface: it accepts a length-prefixed, checksummed byte stream over a valid/ready handshake and assembles 32-bit instruction words. It writes them to consecutive addresses starting at 0, and holds the processor stalled until a load completes with a good checksum.

Parameters:
ADDR_W, 5, instruction memory address width (matches the 5-bit pc).
DATA_W, 32, instruction word width; fixed at 4 bytes per word.
DEPTH, 32, maximum number of words per load (2**ADDR_W).

Ports:
clock  input  1  system clock; all state changes on posedge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin a new load; sampled only in IDLE, DONE or ERR.
byte_in  input  8  stream byte.
byte_valid  input  1  byte_in is valid.
byte_ready  output  1  loader accepts byte this cycle.
mem_we  output  1  instruction memory write strobe, one cycle per word.
mem_addr  output  ADDR_W  write address.
mem_wdata  output  DATA_W  instruction word being written.
words_loaded  output  ADDR_W+1  count of words written in the current or last load.
cpu_hold  output  1  keeps the processor from fetching.
done  output  1  last load completed with a good checksum.
error  output  1  last load failed (bad length or checksum).

Behaviour:
- Reset values: state IDLE; byte_ready=0; mem_we=0; mem_addr=0; mem_wdata=0; words_loaded=0; cpu_hold=1; done=0; error=0. Internal byte index, word count N, and checksum all clear to 0.
- Handshake: a byte transfers only on a posedge where byte_valid and byte_ready are both 1. byte_ready is 1 only in LEN, DATA and CSUM. It is combinational from state and does not depend on byte_valid.
- States and transitions:
  - IDLE: start -> LEN. Also clears words_loaded, the checksum, mem_addr and the byte index; sets cpu_hold=1, done=0, error=0.
  - LEN: the accepted byte is N.
    - N=0 or N>DEPTH -> ERR.
    - Otherwise store N and go to DATA.
    - The length byte is not included in the checksum.
  - DATA: accepted bytes fill the word MSB first. Byte 0 -> bits 31:24, which carry the opcode field 31:27; byte 3 -> bits 7:0. Every data byte is XORed into the checksum.
  - Word completion: on acceptance of byte 3, the next cycle has mem_we=1, mem_wdata=the assembled word, mem_addr=the word index. On that cycle words_loaded increments; mem_addr advances one cycle later.
  - Write rate: at most one write per 4 accepted bytes, so no back-pressure is needed.
  - After byte 3 of word N-1 -> CSUM.
  - CSUM: the accepted byte is compared with the running XOR. Equal -> DONE; unequal -> ERR.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start -> LEN, with the same clears as from IDLE.
  - ERR: error=1, cpu_hold=1, byte_ready=0. start -> LEN, with the same clears as from IDLE.
- Latency: done and cpu_hold change on the clock edge after the checksum byte is accepted. A 1-word load takes 6 accepted bytes minimum.
- Boundary conditions:
  - start in LEN, DATA or CSUM is ignored.
  - byte_valid low mid-word stalls with no state change; a partial word is held indefinitely.
  - N=DEPTH writes addresses 0..31, and the final mem_addr value stays 31 (no wrap-around is used).
  - Words beyond N are not cleared; prior memory contents remain.
  - Words written before a checksum failure stay in memory, but cpu_hold stays 1.
  - reset asserted mid-load aborts immediately. All outputs return to reset values the next edge, and no mem_we is issued for a partial word.
  - start and byte_valid asserted together in IDLE: the byte is not accepted (byte_ready=0 that cycle).

Test Plan:
- Reset, then start; stream 01, 80,40,00,21, checksum 80^40^00^21=E1. Expect one mem_we at addr 0, data 32'h80400021; words_loaded=1; done=1; cpu_hold=0.
- Load N=3 with byte_valid toggled 0/1 every cycle. Expect writes to addr 0,1,2 with correct words, exactly 3 mem_we pulses, done=1.
- Same as the first test but checksum byte E0. Expect error=1, done=0, cpu_hold=1, with addr 0 still written once.
- Length byte 00, and separately 21 (33). Expect ERR on the next edge, no mem_we, byte_ready=0.
- N=32 full load with a correct checksum. Expect addresses 0..31 in order, words_loaded=32, done=1.
- Assert reset after 2 bytes of word 1. Expect no further mem_we and all outputs at reset values. A following start plus a clean 1-word load then succeeds.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream handshake between a program source and the loader.
//   byte_in    : stream byte, driven by the source
//   byte_valid : byte_in holds a byte, driven by the source
//   byte_ready : loader takes the byte this cycle, driven by the loader
// Valid/ready: a byte moves on a posedge where byte_valid and byte_ready
// are both 1. The source keeps byte_in stable while byte_valid waits for
// byte_ready. byte_ready never depends on byte_valid.
// modport master = byte source, modport slave = loader.
interface prog_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_in, output byte_valid, input byte_ready);
  modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/prog_loader.sv
// Program loader: takes a length-prefixed, XOR-checksummed byte stream and
// writes 32-bit instruction words into instruction memory from address 0.
// The processor stays stalled until a load ends with a good checksum.
// Stream format: N (1..DEPTH), then N words of 4 bytes each (MSB first),
// then one byte equal to the XOR of all data bytes.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   start         : begin a new load (only honoured in IDLE, DONE, ERR)
//   stream        : byte handshake (slave side)
//   mem_we/addr/wdata : instruction memory write port, one strobe per word
//   words_loaded  : words written in the current or last load
//   cpu_hold      : stalls the processor
//   done / error  : outcome of the last load
//   state_dbg     : current FSM state, for observation only
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      stream,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

  state_t          state;
  logic [1:0]      byte_idx;   // position of the next data byte in its word
  logic [ADDR_W:0] n_words;    // word count taken from the length byte
  logic [7:0]      csum;       // running XOR of data bytes
  logic [23:0]     word_buf;   // first three bytes of the word in progress
  logic            accept;
  logic            len_bad;

  assign stream.byte_ready = (state == S_LEN) || (state == S_DATA) ||
                             (state == S_CSUM);
  assign accept    = stream.byte_valid && stream.byte_ready;
  assign len_bad   = (stream.byte_in == 8'd0) ||
                     ({1'b0, stream.byte_in} > DEPTH_B);
  assign state_dbg = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      byte_idx     <= 2'd0;
      n_words      <= '0;
      csum         <= 8'd0;
      word_buf     <= 24'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      mem_we <= 1'b0;

      // The address moves on once the write strobe has been seen, but not
      // after the final word, so it rests on the last written address.
      if (mem_we && (words_loaded != n_words)) begin
        mem_addr <= mem_addr + 1'b1;
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            words_loaded <= '0;
            csum         <= 8'd0;
            mem_addr     <= '0;
            byte_idx     <= 2'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
          end
        end

        S_LEN: begin
          if (accept) begin
            if (len_bad) begin
              state <= S_ERR;
              error <= 1'b1;
            end else begin
              n_words <= stream.byte_in[ADDR_W:0];
              state   <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ stream.byte_in;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[23:16] <= stream.byte_in;
              2'd1: word_buf[15:8]  <= stream.byte_in;
              2'd2: word_buf[7:0]   <= stream.byte_in;
              default: begin
                mem_we       <= 1'b1;
                mem_wdata    <= {word_buf, stream.byte_in};
                words_loaded <= words_loaded + 1'b1;
                if ((words_loaded + 1'b1) == n_words) begin
                  state <= S_CSUM;
                end
              end
            endcase
          end
        end

        S_CSUM: begin
          if (accept) begin
            if (stream.byte_in == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
